// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter with cycle-long grant, fixed or
// round-robin tie-break, and a watchdog that aborts unanswered strobes.
module wb_bus_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_addr_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  output logic [1:0]  gnt_o
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT0, ABORT1} state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;   // 1 = master 1 was granted most recently
  logic [WDW-1:0] wdog_q, wdog_d;

  logic [1:0]        m_cyc, m_stb, m_we, m_ack, m_err;
  logic [1:0][3:0]   m_sel;
  logic [1:0][31:0]  m_addr, m_dat;

  assign m_cyc  = {m1_cyc_i,  m0_cyc_i};
  assign m_stb  = {m1_stb_i,  m0_stb_i};
  assign m_we   = {m1_we_i,   m0_we_i};
  assign m_sel  = {m1_sel_i,  m0_sel_i};
  assign m_addr = {m1_addr_i, m0_addr_i};
  assign m_dat  = {m1_dat_i,  m0_dat_i};

  logic granted, aborting, owner, timeout;

  function automatic state_t gnt_state(input logic x);
    return x ? GNT1 : GNT0;
  endfunction

  always_comb begin
    granted  = (state_q == GNT0)   || (state_q == GNT1);
    aborting = (state_q == ABORT0) || (state_q == ABORT1);
    owner    = (state_q == GNT1)   || (state_q == ABORT1);
    // An ack/err arriving on the final watchdog cycle still wins.
    timeout  = granted && m_stb[owner] && !wbs_ack_i && !wbs_err_i &&
               (wdog_q == WD_LAST);
  end

  always_comb begin
    state_d = state_q;
    wdog_d  = '0;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m_cyc[0] && m_cyc[1])
          state_d = gnt_state(ROUND_ROBIN ? ~last_q : 1'b0);
        else if (m_cyc[0])
          state_d = GNT0;
        else if (m_cyc[1])
          state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (!m_cyc[owner])
          state_d = m_cyc[~owner] ? gnt_state(~owner) : IDLE;
        else if (timeout)
          state_d = owner ? ABORT1 : ABORT0;
        else if (m_stb[owner] && !wbs_ack_i && !wbs_err_i)
          wdog_d = wdog_q + 1'b1;
      end
      ABORT0, ABORT1: begin
        if (!m_cyc[owner])
          state_d = m_cyc[~owner] ? gnt_state(~owner) : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0)      last_d = 1'b0;
    else if (state_d == GNT1) last_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  // Bus outputs are gated by rst_i directly so a mid-cycle reset drops cyc at once.
  always_comb begin
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    wbs_we_o   = 1'b0;
    wbs_sel_o  = '0;
    wbs_addr_o = '0;
    wbs_dat_o  = '0;
    gnt_o      = '0;
    m_ack      = '0;
    m_err      = '0;
    if (!rst_i) begin
      if (granted) begin
        wbs_cyc_o      = m_cyc[owner];
        wbs_stb_o      = m_stb[owner];
        wbs_we_o       = m_we[owner];
        wbs_sel_o      = m_sel[owner];
        wbs_addr_o     = m_addr[owner];
        wbs_dat_o      = m_dat[owner];
        gnt_o[owner]   = 1'b1;
        m_ack[owner]   = wbs_ack_i;
        m_err[owner]   = wbs_err_i | timeout;
      end else if (aborting) begin
        gnt_o[owner]   = 1'b1;
      end
    end
  end

  assign m0_ack_o = m_ack[0];
  assign m1_ack_o = m_ack[1];
  assign m0_err_o = m_err[0];
  assign m1_err_o = m_err[1];
  assign m0_dat_o = wbs_dat_i;
  assign m1_dat_o = wbs_dat_i;

endmodule
